motor_pwm_gen: RTL and testbench
================================

Name: motor_pwm_gen

Overview:
- Final drive stage of the ESC chain; sits directly downstream of the motor mixer (thrust ± roll/pitch/yaw).
- Takes four signed per-motor force commands and produces four period-synchronous PWM outputs.
- Contains an arming state machine with an idle-spin arming phase and a command-loss watchdog that forces motors off.

Parameters:
- IN_W, 10, width of each signed force input (two's complement).
- CNT_W, 8, width of the period counter and of duty values.
- PERIOD, 200, PWM period in clk cycles; must be ≤ 2^CNT_W.
- IDLE_DUTY, 10, duty used while arming and added as the floor in ARMED.
- ARM_PERIODS, 4, number of full idle periods spent in ARMING.
- TIMEOUT_PERIODS, 3, consecutive periods without force_valid that trigger FAILSAFE.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- force_0..force_3  in  IN_W each  signed motor force commands from the mixer.
- force_valid  in  1  one-cycle strobe; all four forces are valid in this cycle.
- arm  in  1  level; 1 = arm request, 0 = disarm.
- pwm_0..pwm_3  out  1 each  registered PWM outputs.
- state  out  2  00 DISARMED, 01 ARMING, 10 ARMED, 11 FAILSAFE.
- period_start  out  1  registered pulse, high while cnt==0.
- failsafe  out  1  high while state==FAILSAFE.

Behaviour:
- Reset (reset==0, asynchronous):
  - cnt=0, state=DISARMED; all pwm_i, period_start and failsafe =0.
  - Shadow and active duties =0; arm-period and watchdog counters =0.
- Counter:
  - cnt runs 0..PERIOD-1 and wraps, free-running in every state.
  - The period boundary is the cycle where cnt==PERIOD-1.
- Force conversion, evaluated on force_valid:
  - Clamp each force: if force<0, use 0; if force>PERIOD-IDLE_DUTY, use PERIOD-IDLE_DUTY.
  - duty = IDLE_DUTY + clamped value. Result fits CNT_W with no wrap.
  - The result is written to the shadow register.
- Duty commit:
  - Active duty loads only at the period boundary, so it takes effect from cnt==0.
  - Duties never change mid-period.
  - If force_valid and the boundary occur in the same cycle, the commit uses the old shadow value; the new value applies one period later.
- Output:
  - pwm_i is registered: it equals (cnt < active_duty_i) AND (state is ARMING or ARMED), delayed one cycle.
  - duty==PERIOD gives a constant high output; duty 0 gives constant low.
- FSM:
  - DISARMED → ARMING: at a boundary with arm==1. Shadow and active duties are set to IDLE_DUTY; the arm-period counter is cleared.
  - ARMING → ARMED: after ARM_PERIODS complete boundaries. force_valid is accepted into the shadow during ARMING, but active duty stays IDLE_DUTY.
  - ARMED: active duty comes from the shadow at each boundary.
  - Watchdog (ARMED only):
    - At each boundary, if no force_valid arrived since the previous boundary, increment the counter; otherwise clear it.
    - When the counter reaches TIMEOUT_PERIODS, go to FAILSAFE.
  - FAILSAFE: pwm low, failsafe=1. Exits only to DISARMED, when arm==0.
  - Any state: arm==0 sends state to DISARMED on the next clock, regardless of the boundary. Duties are cleared and pwm goes low one cycle later.
  - Simultaneous arm==0 and watchdog timeout: DISARMED wins.
- Reset mid-operation: outputs go low asynchronously and the FSM restarts from DISARMED.
- force_valid in DISARMED or FAILSAFE is ignored.

Decomposition:
- Package esc_pkg:
  - pwm_state_t enum (DISARMED/ARMING/ARMED/FAILSAFE with the encodings above).
  - Default constants PERIOD, IDLE_DUTY, ARM_PERIODS, TIMEOUT_PERIODS.
  - A clamp function for force-to-duty conversion.
- One sub-module, pwm_channel, instantiated 4×:
  - Holds clamp, shadow register, active register, compare and output flop.
  - Takes load_shadow, commit, force_idle, enable and cnt from the top.
- The top holds the counter, FSM, watchdog and arm-period counter.

Test Plan:
1. Reset release with arm=0 → state=00, all pwm low for 3 periods, period_start pulses every 200 cycles.
2. arm=1 → ARMING at the next boundary; each pwm high 10 cycles per period for exactly 4 periods, then state=10.
3. ARMED; force_0=50, force_1=-5, force_2=250, force_3=190 with valid → from the next period, high for 60, 10, 200 (constant high) and 200 cycles respectively.
4. ARMED at duty 60; valid at cnt=50 with force 20 → current period stays high 60 cycles, next period high 30; valid at cnt==199 → change delayed by one extra period.
5. Stop force_valid in ARMED → after 3 boundaries state=11, failsafe=1, pwm low; arm=0 → state=00; arm=1 → re-arming sequence as in scenario 2.
6. Assert reset low at cnt=30 in ARMED → pwm, state and failsafe =0 immediately; arm=0 during ARMING → DISARMED next clock, pwm low one cycle later.

Source files
------------

// File: rtl/esc_pkg.sv
// esc_pkg: shared state encoding, default parameters and force-to-duty conversion for the ESC drive stage
package esc_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'b00,
        ARMING   = 2'b01,
        ARMED    = 2'b10,
        FAILSAFE = 2'b11
    } pwm_state_t;

    localparam int DEF_IN_W            = 10;
    localparam int DEF_CNT_W           = 8;
    localparam int DEF_PERIOD          = 200;
    localparam int DEF_IDLE_DUTY       = 10;
    localparam int DEF_ARM_PERIODS     = 4;
    localparam int DEF_TIMEOUT_PERIODS = 3;

    // Negative forces fall to the idle floor; large forces saturate at a full period.
    function automatic int force_to_duty(int f, int period, int idle);
        int lim;
        lim = period - idle;
        return idle + (f < 0 ? 0 : (f > lim ? lim : f));
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one motor output; converts a force to a duty, double-buffers it and compares against the shared counter
module pwm_channel
    import esc_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int PERIOD    = DEF_PERIOD,
    parameter int IDLE_DUTY = DEF_IDLE_DUTY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  force_in,
    input  logic             load_shadow,
    input  logic             commit,
    input  logic             force_idle,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm
);

    localparam logic [CNT_W-1:0] IDLE = CNT_W'(IDLE_DUTY);

    logic [CNT_W-1:0] shadow, active, duty_new;

    assign duty_new = CNT_W'(force_to_duty(int'($signed(force_in)), PERIOD, IDLE_DUTY));

    // Shadow takes new commands any time; active only changes at the period boundary, so duties never glitch mid-period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            shadow <= clear ? '0 : force_idle ? IDLE : load_shadow ? duty_new : shadow;
            active <= clear ? '0 : force_idle ? IDLE : commit ? shadow : active;
            pwm    <= enable && (cnt < active);
        end
    end

endmodule

// File: rtl/motor_pwm_gen.sv
// motor_pwm_gen: four-channel motor PWM stage with arming sequence and command-loss watchdog
module motor_pwm_gen
    import esc_pkg::*;
#(
    parameter int IN_W            = DEF_IN_W,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int PERIOD          = DEF_PERIOD,
    parameter int IDLE_DUTY       = DEF_IDLE_DUTY,
    parameter int ARM_PERIODS     = DEF_ARM_PERIODS,
    parameter int TIMEOUT_PERIODS = DEF_TIMEOUT_PERIODS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] force_0,
    input  logic [IN_W-1:0] force_1,
    input  logic [IN_W-1:0] force_2,
    input  logic [IN_W-1:0] force_3,
    input  logic            force_valid,
    input  logic            arm,
    output logic            pwm_0,
    output logic            pwm_1,
    output logic            pwm_2,
    output logic            pwm_3,
    output logic [1:0]      state,
    output logic            period_start,
    output logic            failsafe
);

    localparam int ARM_W = $clog2(ARM_PERIODS + 1);
    localparam int WD_W  = $clog2(TIMEOUT_PERIODS + 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(PERIOD - 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_PERIODS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_PERIODS - 1);

    pwm_state_t st, st_nx;
    logic [CNT_W-1:0] cnt;
    logic [ARM_W-1:0] arm_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             seen, bnd, got_cmd, timeout;
    logic             load_shadow, commit, force_idle, clear, enable;
    logic [IN_W-1:0]  forces [4];
    logic [3:0]       pwm;

    assign bnd         = cnt == LAST;
    assign got_cmd     = seen || force_valid;
    assign timeout     = st == ARMED && bnd && !got_cmd && wd_cnt == WD_LAST;
    assign clear       = !arm;
    assign force_idle  = st == DISARMED && bnd && arm;
    assign enable      = st == ARMING || st == ARMED;
    assign load_shadow = force_valid && arm && enable;
    assign commit      = bnd && arm && st == ARMED;
    assign state       = st;
    assign failsafe    = st == FAILSAFE;
    assign forces      = '{force_0, force_1, force_2, force_3};
    assign {pwm_3, pwm_2, pwm_1, pwm_0} = pwm;

    // Free-running period counter and the registered period_start pulse aligned to cnt==0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= bnd ? '0 : cnt + 1'b1;
            period_start <= bnd;
        end
    end

    // Arm-period counter, per-period command-seen flag and watchdog count of silent periods.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arm_cnt <= '0;
            wd_cnt  <= '0;
            seen    <= 1'b0;
        end else begin
            arm_cnt <= st != ARMING ? '0 : bnd ? arm_cnt + 1'b1 : arm_cnt;
            wd_cnt  <= st != ARMED ? '0 : !bnd ? wd_cnt : got_cmd ? '0 : wd_cnt + 1'b1;
            seen    <= bnd ? 1'b0 : got_cmd;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= DISARMED;
        else        st <= st_nx;
    end

    // Next state; dropping arm overrides everything, including a simultaneous watchdog timeout.
    always_comb begin
        st_nx = st;
        case (st)
            DISARMED: st_nx = bnd ? ARMING : DISARMED;
            ARMING:   st_nx = (bnd && arm_cnt == ARM_LAST) ? ARMED : ARMING;
            ARMED:    st_nx = timeout ? FAILSAFE : ARMED;
            default:  st_nx = FAILSAFE;
        endcase
        if (!arm) st_nx = DISARMED;
    end

    for (genvar i = 0; i < 4; i++) begin : g_ch
        pwm_channel #(
            .IN_W(IN_W), .CNT_W(CNT_W), .PERIOD(PERIOD), .IDLE_DUTY(IDLE_DUTY)
        ) u_ch (
            .clk(clk), .reset(reset), .force_in(forces[i]),
            .load_shadow(load_shadow), .commit(commit), .force_idle(force_idle),
            .clear(clear), .enable(enable), .cnt(cnt), .pwm(pwm[i])
        );
    end

endmodule

// File: tb/tb_motor_pwm_gen.sv
// tb_motor_pwm_gen: directed and randomized checks of motor_pwm_gen against a per-period behavioural model
module tb_motor_pwm_gen;

    localparam int P    = 200;
    localparam int IDLE = 10;

    logic       clk = 1'b0, reset = 1'b1, force_valid = 1'b0, arm = 1'b0;
    logic [9:0] force_0 = '0, force_1 = '0, force_2 = '0, force_3 = '0;
    logic       pwm_0, pwm_1, pwm_2, pwm_3, period_start, failsafe;
    logic [1:0] state;

    int tcnt = 0, passed = 0, total = 0;
    int m_state = 0, m_wd = 0, m_arm = 0;
    int m_act[4] = '{0, 0, 0, 0};
    int m_sh[4]  = '{0, 0, 0, 0};

    motor_pwm_gen dut (
        .clk(clk), .reset(reset),
        .force_0(force_0), .force_1(force_1), .force_2(force_2), .force_3(force_3),
        .force_valid(force_valid), .arm(arm),
        .pwm_0(pwm_0), .pwm_1(pwm_1), .pwm_2(pwm_2), .pwm_3(pwm_3),
        .state(state), .period_start(period_start), .failsafe(failsafe)
    );

    always #5 clk = ~clk;

    // Reference position within the PWM period.
    always @(posedge clk or negedge reset) tcnt <= !reset ? 0 : (tcnt + 1) % P;

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int ref_duty(input logic [9:0] f);
        int v;
        v = $signed(f);
        if (v < 0) return IDLE;
        if (v > P - IDLE) return P;
        return v + IDLE;
    endfunction

    task automatic model_disarm();
        m_state = 0; m_wd = 0; m_arm = 0;
        m_act = '{0, 0, 0, 0};
        m_sh  = '{0, 0, 0, 0};
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        while (tcnt != v && n < 2 * P) begin
            @(negedge clk);
            n++;
        end
        if (tcnt != v) chk("wait_cnt", tcnt, v);
    endtask

    // One full period window (pwm for cnt 0..199); optional valid strobe at cnt==vc.
    task automatic period(input logic a, input int vc, input int f0, input int f1, input int f2, input int f3);
        int hi[4];
        int ps, exp_hi;
        logic [9:0] fv[4];
        logic valid;
        hi = '{0, 0, 0, 0};
        ps = 0;
        fv[0] = f0[9:0]; fv[1] = f1[9:0]; fv[2] = f2[9:0]; fv[3] = f3[9:0];
        wait_cnt(1);
        arm = a;
        {force_0, force_1, force_2, force_3} = {fv[0], fv[1], fv[2], fv[3]};
        for (int i = 0; i < P; i++) begin
            force_valid = (tcnt == vc);
            hi[0] += int'(pwm_0); hi[1] += int'(pwm_1);
            hi[2] += int'(pwm_2); hi[3] += int'(pwm_3);
            ps += int'(period_start);
            @(negedge clk);
        end
        force_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            exp_hi = (m_state == 1 || m_state == 2) ? m_act[c] : 0;
            chk($sformatf("pwm%0d_high_cycles", c), hi[c], exp_hi);
        end
        chk("period_start_pulses", ps, 1);
        valid = vc >= 1 && vc < P;
        case (m_state)
            0: if (a) begin
                m_state = 1; m_arm = 0;
                m_act = '{IDLE, IDLE, IDLE, IDLE};
                m_sh  = '{IDLE, IDLE, IDLE, IDLE};
            end
            1: begin
                if (valid) for (int c = 0; c < 4; c++) m_sh[c] = ref_duty(fv[c]);
                m_arm++;
                if (m_arm == 4) begin m_state = 2; m_wd = 0; end
            end
            2: begin
                for (int c = 0; c < 4; c++) begin
                    if (valid && vc == P - 1) begin
                        m_act[c] = m_sh[c];
                        m_sh[c]  = ref_duty(fv[c]);
                    end else begin
                        if (valid) m_sh[c] = ref_duty(fv[c]);
                        m_act[c] = m_sh[c];
                    end
                end
                m_wd = valid ? 0 : m_wd + 1;
                if (m_wd == 3) m_state = 3;
            end
            default: ;
        endcase
        chk("state", state, m_state);
        chk("failsafe", failsafe, m_state == 3);
    endtask

    initial begin
        int vc;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_pwm", {pwm_3, pwm_2, pwm_1, pwm_0}, 0);
        chk("reset_period_start", period_start, 0);
        chk("reset_failsafe", failsafe, 0);
        reset = 1'b1;

        repeat (3) period(1'b0, -1, 0, 0, 0, 0);
        repeat (5) period(1'b1, -1, 0, 0, 0, 0);

        period(1'b1, 100, 50, -5, 250, 190);
        period(1'b1, 100, 50, -5, 250, 190);
        period(1'b1, 50, 20, -5, 250, 190);
        period(1'b1, 199, 70, -5, 250, 190);
        period(1'b1, 100, 70, -5, 250, 190);
        period(1'b1, 100, 50, -5, 250, 190);
        repeat (4) period(1'b1, -1, 50, -5, 250, 190);

        arm = 1'b0;
        @(negedge clk);
        chk("disarm_from_failsafe_state", state, 0);
        chk("disarm_from_failsafe_flag", failsafe, 0);
        model_disarm();

        repeat (5) period(1'b1, -1, 0, 0, 0, 0);
        period(1'b1, 100, 50, 0, 0, 0);

        wait_cnt(30);
        chk("pre_reset_pwm0", pwm_0, 1);
        reset = 1'b0;
        #1;
        chk("async_reset_pwm", {pwm_3, pwm_2, pwm_1, pwm_0}, 0);
        chk("async_reset_state", state, 0);
        chk("async_reset_failsafe", failsafe, 0);
        @(negedge clk);
        reset = 1'b1;
        model_disarm();

        repeat (2) period(1'b1, -1, 0, 0, 0, 0);
        wait_cnt(5);
        chk("arming_pwm0_before_disarm", pwm_0, 1);
        chk("arming_state_before_disarm", state, 1);
        arm = 1'b0;
        @(negedge clk);
        chk("disarm_next_clock_state", state, 0);
        chk("disarm_pwm_still_high", pwm_0, 1);
        @(negedge clk);
        chk("disarm_pwm_low_after", {pwm_3, pwm_2, pwm_1, pwm_0}, 0);
        model_disarm();

        for (int k = 0; k < 20; k++) begin
            vc = ($urandom_range(9) == 0) ? -1 : ($urandom_range(4) == 0) ? P - 1 : int'($urandom_range(P - 2, 1));
            period(1'b1, vc, int'($urandom_range(1023)) - 512, int'($urandom_range(1023)) - 512,
                   int'($urandom_range(1023)) - 512, int'($urandom_range(1023)) - 512);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
